// File: rtl/reg_dump_uart_tx_pkg.sv
// Shared frame constants and FSM state type for the register-dump UART reader.
package rv_debug_pkg;
    localparam logic [7:0] FRAME_HDR    = 8'hA5;
    localparam int         FRAME_BYTES  = 30;
    localparam int         NUM_DBG_REGS = 7;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} dump_state_t;
endpackage

// File: rtl/reg_dump_uart_tx_if.sv
// Board-level bundle: dump request, register taps in; UART line and status out.
interface reg_dump_uart_tx_if;
    logic                      start;
    logic [31:0]               debug_x1;
    logic [31:0]               debug_x2;
    logic [31:0]               debug_x3;
    logic [31:0]               debug_x4;
    logic [31:0]               debug_x5;
    logic [31:0]               debug_x6;
    logic [31:0]               debug_x7;
    logic                      tx;
    logic                      busy;
    logic                      done;
    rv_debug_pkg::dump_state_t fsm_state;
    rv_debug_pkg::dump_state_t ser_state;

    modport master (
        output start, debug_x1, debug_x2, debug_x3, debug_x4, debug_x5, debug_x6, debug_x7,
        input  tx, busy, done, fsm_state, ser_state
    );
    modport slave (
        input  start, debug_x1, debug_x2, debug_x3, debug_x4, debug_x5, debug_x6, debug_x7,
        output tx, busy, done, fsm_state, ser_state
    );
endinterface

// File: rtl/reg_dump_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer: owns the baud counter, the START/DATA/STOP bit phases and the tx line.
module uart_tx_byte
    import rv_debug_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        tx,
    output dump_state_t state
);
    localparam int             CW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          bit_end;

    assign bit_end = (cnt == CNT_LAST);
    // A byte transfers on any edge where in_valid && in_ready. in_ready is also high in the
    // last stop-bit cycle so back-to-back bytes leave no idle gap on the line.
    assign in_ready = (state == IDLE) || ((state == STOP) && bit_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh    <= in_data;
                        tx    <= 1'b0;
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= sh[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            sh      <= sh >> 1;
                            tx      <= sh[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (in_valid) begin
                            sh    <= in_data;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/reg_dump_uart_tx.sv
// Snapshots debug taps x1..x7 on request and streams them as a 30-byte UART frame.
module reg_dump_uart_tx
    import rv_debug_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_dump_uart_tx_if.slave bus
);
    localparam int         DIV      = CLK_HZ / BAUD;
    localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);

    if (DIV < 2) begin : g_div_check
        $error("reg_dump_uart_tx: CLK_HZ/BAUD must be at least 2");
    end

    dump_state_t state;
    logic [31:0] snap [NUM_DBG_REGS];
    logic [4:0]  byte_idx;
    logic [4:0]  data_off;
    logic [7:0]  chk;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;

    // Byte 0 is the header, 1..28 the registers MSB byte first, 29 the running checksum.
    always_comb begin
        data_off = byte_idx - 5'd1;
        in_data  = FRAME_HDR;
        if (byte_idx == LAST_IDX) begin
            in_data = chk;
        end else if (byte_idx != 5'd0) begin
            case (data_off[1:0])
                2'd0:    in_data = snap[data_off[4:2]][31:24];
                2'd1:    in_data = snap[data_off[4:2]][23:16];
                2'd2:    in_data = snap[data_off[4:2]][15:8];
                default: in_data = snap[data_off[4:2]][7:0];
            endcase
        end
    end

    assign in_valid      = (state == START);
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_idx <= '0;
            chk      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < NUM_DBG_REGS; i++) snap[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        snap[0]  <= bus.debug_x1;
                        snap[1]  <= bus.debug_x2;
                        snap[2]  <= bus.debug_x3;
                        snap[3]  <= bus.debug_x4;
                        snap[4]  <= bus.debug_x5;
                        snap[5]  <= bus.debug_x6;
                        snap[6]  <= bus.debug_x7;
                        byte_idx <= '0;
                        chk      <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (in_ready) begin
                        busy <= 1'b1;
                        if (byte_idx != 5'd0 && byte_idx != LAST_IDX) chk <= chk ^ in_data;
                        if (byte_idx == LAST_IDX) state <= STOP;
                        else byte_idx <= byte_idx + 5'd1;
                    end
                end
                STOP: begin
                    // Serializer ready again means the last stop bit has just finished.
                    if (in_ready) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx       (bus.tx),
        .state    (bus.ser_state)
    );
endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Bench for reg_dump_uart_tx at DIV=16: frame content, bit timing, snapshot, restart and async reset.
module tb_reg_dump_uart_tx;
    import rv_debug_pkg::*;

    logic clk;
    logic rst_n;
    reg_dump_uart_tx_if bus ();

    reg_dump_uart_tx #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [7:0]  exp_q [$];
    logic [9:0]  raw_hist [$];
    logic [31:0] regs [7];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- common check ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_regs();
        bus.debug_x1 = regs[0];
        bus.debug_x2 = regs[1];
        bus.debug_x3 = regs[2];
        bus.debug_x4 = regs[3];
        bus.debug_x5 = regs[4];
        bus.debug_x6 = regs[5];
        bus.debug_x7 = regs[6];
    endtask

    task automatic push_exp(input logic [7:0] chk);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 7; i++)
            for (int j = 3; j >= 0; j--) exp_q.push_back(regs[i][8*j +: 8]);
        exp_q.push_back(chk);
    endtask

    task automatic begin_frame(input logic [7:0] chk, output int b0, output int d0);
        drive_regs();
        raw_hist.delete();
        push_exp(chk);
        b0 = busy_cnt;
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", tag, n);
        end
    endtask

    task automatic end_frame(input string tag, input int b0, input int d0);
        wait_done(tag);
        repeat (3) @(negedge clk);
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_busy_len"}, busy_cnt - b0, 4800);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic rx_byte();
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        logic [7:0] exp;
        bits    = '0;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < 16; s++) begin
                if (!(b == 0 && s == 0)) @(negedge clk);
                if (!rst_n) begin
                    aborted = 1'b1;
                    break;
                end
                if (s == 0) bits[b] = bus.tx;
                else if (bus.tx !== bits[b]) stable = 1'b0;
            end
            if (aborted) break;
        end
        if (!aborted) begin
            raw_hist.push_back(bits);
            check("bit_timing", stable, 1);
            check("stop_bit", bits[9], 1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_byte: got %0h expected none", bits[8:1]);
            end else begin
                exp = exp_q.pop_front();
                check("rx_byte", bits[8:1], exp);
            end
        end
    endtask

    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.tx === 1'b0) rx_byte();
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int b0, d0, n;
        logic idle_ok;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) regs[i] = '0;
        drive_regs();
        repeat (3) @(negedge clk);
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_state", bus.fsm_state, IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: x1..x7 = 1..7, checksum 00, plus first-byte latency
        regs = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        begin_frame(8'h00, b0, d0);
        check("t1_tx_before", bus.tx, 1);
        check("t1_busy_before", bus.busy, 0);
        @(negedge clk);
        check("t1_tx_start", bus.tx, 0);
        check("t1_busy_start", bus.busy, 1);
        end_frame("t1", b0, d0);

        // 2: DEADBEEF, checksum 22, DE on the line LSB first
        regs = '{32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        begin_frame(8'h22, b0, d0);
        end_frame("t2", b0, d0);
        check("t2_line_DE", (raw_hist.size() > 1) ? {22'd0, raw_hist[1]} : 32'hFFFF_FFFF, 32'h3BC);

        // 3: x3 changes mid-frame, snapshot must hold
        regs = '{32'd0, 32'd0, 32'h11111111, 32'd0, 32'd0, 32'd0, 32'd0};
        begin_frame(8'h00, b0, d0);
        repeat (370) @(negedge clk);
        bus.debug_x3 = 32'hFFFFFFFF;
        end_frame("t3", b0, d0);

        // 4: start during byte 5 ignored; start held across done restarts
        regs = '{32'h01020304, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        begin_frame(8'h04, b0, d0);
        repeat (850) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3800) @(negedge clk);
        push_exp(8'h04);
        bus.start = 1'b1;
        wait_done("t4a");
        @(negedge clk);
        check("t4a_busy_len", busy_cnt - b0, 4800);
        check("t4a_done_cnt", done_cnt - d0, 1);
        check("t4a_bytes_left", exp_q.size(), 30);
        b0 = busy_cnt;
        d0 = done_cnt;
        n  = 1;
        while (bus.tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_restart_gap", n, 3);
        bus.start = 1'b0;
        end_frame("t4b", b0, d0);

        // 5: async reset mid-bit in byte 10
        regs = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hA5A5A5A5, 32'd0, 32'd0};
        begin_frame(8'h00, b0, d0);
        repeat (1659) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_tx", bus.tx, 1);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_state", bus.fsm_state, IDLE);
        check("t5_rst_ser_state", bus.ser_state, IDLE);
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        idle_ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) idle_ok = 1'b0;
        end
        check("t5_idle_after_rst", idle_ok, 1);

        // 6: x7 = 80000001, checksum 81, last data byte 01 on the line
        regs = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h80000001};
        begin_frame(8'h81, b0, d0);
        end_frame("t6", b0, d0);
        check("t6_nbytes", raw_hist.size(), 30);
        check("t6_line_01", (raw_hist.size() > 28) ? {22'd0, raw_hist[28]} : 32'hFFFF_FFFF, 32'h202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
